// File: rtl/miriscv_lsu.sv
// Load/store unit: turns core byte/half/word accesses into word-aligned RAM
// transactions and formats the returned word for the core.
//
// state | meaning
// IDLE  | no access outstanding; an aligned request is issued combinationally
// WAIT  | request issued; waiting for data_rvalid_i or the response timeout
module miriscv_lsu #(
  parameter int unsigned RSP_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_stall_o,
  output logic        lsu_done_o,
  output logic        lsu_misalign_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  localparam int unsigned CW = (RSP_TIMEOUT > 2) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RSP_TIMEOUT - 1);

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    off_q;
  logic [2:0]    size_q;
  logic          we_q;

  logic          is_byte, is_half, is_word;
  logic          misalign, issue, cnt_last;
  logic [31:0]   sel;
  logic [31:0]   load_fmt;

  // request decode; undefined size codes behave as a word access
  always_comb begin
    is_byte  = (lsu_size_i == SZ_B) || (lsu_size_i == SZ_BU);
    is_half  = (lsu_size_i == SZ_H) || (lsu_size_i == SZ_HU);
    is_word  = !is_byte && !is_half;
    misalign = (is_half && lsu_addr_i[0]) || (is_word && (lsu_addr_i[1:0] != 2'b00));
    issue    = (state_q == S_IDLE) && lsu_req_i && !misalign;
    cnt_last = (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        cnt_q  <= '0;
        off_q  <= lsu_addr_i[1:0];
        size_q <= lsu_size_i;
        we_q   <= lsu_we_i;
      end else if ((state_q == S_WAIT) && !data_rvalid_i && !cnt_last) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue) state_d = S_WAIT;
      S_WAIT:  if (data_rvalid_i || cnt_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel = data_rdata_i >> {off_q, 3'b000};
    case (size_q)
      SZ_B:    load_fmt = {{24{sel[7]}}, sel[7:0]};
      SZ_BU:   load_fmt = {24'h0, sel[7:0]};
      SZ_H:    load_fmt = {{16{sel[15]}}, sel[15:0]};
      SZ_HU:   load_fmt = {16'h0, sel[15:0]};
      default: load_fmt = data_rdata_i;
    endcase
  end

  // outputs are gated by arst_i because the IDLE issue path is combinational
  always_comb begin
    lsu_rdata_o    = '0;
    lsu_stall_o    = 1'b0;
    lsu_done_o     = 1'b0;
    lsu_misalign_o = 1'b0;
    lsu_err_o      = 1'b0;
    data_req_o     = 1'b0;
    data_we_o      = 1'b0;
    data_be_o      = '0;
    data_addr_o    = '0;
    data_wdata_o   = '0;
    if (!arst_i) begin
      case (state_q)
        S_IDLE: begin
          if (lsu_req_i && misalign) begin
            lsu_misalign_o = 1'b1;
            lsu_done_o     = 1'b1;
          end else if (lsu_req_i) begin
            data_req_o  = 1'b1;
            data_we_o   = lsu_we_i;
            data_addr_o = {lsu_addr_i[31:2], 2'b00};
            lsu_stall_o = 1'b1;
            if (is_byte) begin
              data_be_o    = 4'b0001 << lsu_addr_i[1:0];
              data_wdata_o = {4{lsu_wdata_i[7:0]}};
            end else if (is_half) begin
              data_be_o    = 4'b0011 << {lsu_addr_i[1], 1'b0};
              data_wdata_o = {2{lsu_wdata_i[15:0]}};
            end else begin
              data_be_o    = 4'b1111;
              data_wdata_o = lsu_wdata_i;
            end
          end
        end
        S_WAIT: begin
          if (data_rvalid_i) begin
            lsu_done_o  = 1'b1;
            lsu_rdata_o = we_q ? 32'h0 : load_fmt;
          end else if (cnt_last) begin
            lsu_err_o  = 1'b1;
            lsu_done_o = 1'b1;
          end else begin
            lsu_stall_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Scoreboard bench for miriscv_lsu: a byte-array reference memory predicts
// RAM requests and load results; a monitor compares them as the DUT emits them.
module tb_miriscv_lsu;

  localparam int unsigned RSP_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_size = 3'b000;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [31:0] lsu_rdata;
  logic        lsu_stall, lsu_done, lsu_misalign, lsu_err;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  always #5 clk = ~clk;

  miriscv_lsu #(.RSP_TIMEOUT(RSP_TIMEOUT)) dut (
    .clk_i(clk), .arst_i(arst),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_rdata_o(lsu_rdata), .lsu_stall_o(lsu_stall), .lsu_done_o(lsu_done),
    .lsu_misalign_o(lsu_misalign), .lsu_err_o(lsu_err),
    .data_req_o(data_req), .data_we_o(data_we), .data_be_o(data_be),
    .data_addr_o(data_addr), .data_wdata_o(data_wdata),
    .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM model (single-cycle response) ----------------
  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return ({2'b00, wa} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  logic [31:0] ram [logic [29:0]];
  logic [31:0] ram_w;
  logic        rv_q = 1'b0;
  logic [31:0] rd_q = '0;
  bit          drop_rsp = 1'b0;
  bit          force_rvalid = 1'b0;

  assign data_rvalid = rv_q | force_rvalid;
  assign data_rdata  = rd_q;

  always @(posedge clk) begin
    rv_q <= data_req && !drop_rsp;
    if (data_req) begin
      ram_w = ram.exists(data_addr[31:2]) ? ram[data_addr[31:2]] : init_word(data_addr[31:2]);
      rd_q <= ram_w;
      if (data_we) begin
        for (int b = 0; b < 4; b++)
          if (data_be[b]) ram_w[8*b +: 8] = data_wdata[8*b +: 8];
        ram[data_addr[31:2]] = ram_w;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word(a[31:2]);
    return w[8*a[1:0] +: 8];
  endfunction

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iss_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    int          stalls;
  } done_t;

  iss_t  iss_q [$];
  done_t done_q[$];

  // ---------------- monitor ----------------
  int stall_cnt = 0;

  always @(negedge clk) begin
    iss_t  ei;
    done_t ed;
    if (arst) begin
      stall_cnt = 0;
    end else begin
      if (lsu_stall) stall_cnt++;
      if (data_req) begin
        if (iss_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
        else begin
          ei = iss_q.pop_front();
          chk("req_we", {31'd0, data_we}, {31'd0, ei.we});
          chk("req_be", {28'd0, data_be}, {28'd0, ei.be});
          chk("req_addr", data_addr, ei.addr);
          chk("req_wdata", data_wdata, ei.wdata);
        end
      end
      if (lsu_done) begin
        if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          ed = done_q.pop_front();
          chk("rdata", lsu_rdata, ed.rdata);
          chk("misalign", {31'd0, lsu_misalign}, {31'd0, ed.mis});
          chk("err", {31'd0, lsu_err}, {31'd0, ed.err});
          chk("stall_cycles", stall_cnt, ed.stalls);
        end
        stall_cnt = 0;
      end else if (lsu_misalign || lsu_err) begin
        chk("flag_without_done", 32'd1, 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  // Called 1 time unit after a rising edge; returns 1 time unit after the
  // rising edge that ends the done cycle, with the request dropped.
  task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit drop, output logic [31:0] got);
    int    n;
    bit    signed_ld, mis, seen;
    logic [31:0] val, mask;
    iss_t  ei;
    done_t ed;
    case (size)
      3'b000, 3'b100: n = 1;
      3'b001, 3'b101: n = 2;
      default:        n = 4;
    endcase
    signed_ld = (size == 3'b000) || (size == 3'b001);
    mis = (addr % n) != 0;
    lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_wdata = wdata;
    drop_rsp = drop;
    if (mis) begin
      ed = '{rdata: 32'h0, mis: 1'b1, err: 1'b0, stalls: 0};
      done_q.push_back(ed);
    end else begin
      ei.we   = we;
      ei.addr = addr - (addr % 4);
      if (n == 1)      begin ei.be = 4'(1 << (addr % 4)); ei.wdata = {24'h0, wdata[7:0]} * 32'h01010101; end
      else if (n == 2) begin ei.be = 4'(3 << (addr % 4)); ei.wdata = {16'h0, wdata[15:0]} * 32'h00010001; end
      else             begin ei.be = 4'hF; ei.wdata = wdata; end
      iss_q.push_back(ei);
      val = 0;
      for (int i = 0; i < n; i++) val = val + ({24'h0, ref_byte(addr + i)} << (8 * i));
      mask = (n == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * n)) - 1);
      if (signed_ld && n < 4 && val[8*n-1]) val = val | ~mask;
      if (we)
        for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
      ed.rdata  = (we || drop) ? 32'h0 : val;
      ed.mis    = 1'b0;
      ed.err    = drop;
      ed.stalls = drop ? RSP_TIMEOUT : 1;
      done_q.push_back(ed);
    end
    seen = 1'b0;
    got  = '0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (lsu_done) begin seen = 1'b1; got = lsu_rdata; end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    lsu_req = 1'b0;
    drop_rsp = 1'b0;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ctl"}, {24'd0, lsu_stall, lsu_done, lsu_misalign, lsu_err, data_req, data_we, 2'b00},
        32'd0);
    chk({tag, "_be"}, {28'd0, data_be}, 32'd0);
    chk({tag, "_rdata"}, lsu_rdata, 32'd0);
    chk({tag, "_daddr"}, data_addr, 32'd0);
    chk({tag, "_dwdata"}, data_wdata, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [2:0] sizes [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int gap;

    // request held during reset must not leak to the outputs
    lsu_req = 1'b1; lsu_size = 3'b010; lsu_addr = 32'h100; lsu_wdata = 32'h1234_5678; lsu_we = 1'b1;
    #3;
    chk_outs_zero("rst_init");
    lsu_req = 1'b0;
    @(posedge clk); #1;
    arst = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", {31'd0, lsu_stall}, 32'd0);
    @(posedge clk); #1;

    // directed, back-to-back
    do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, got);
    do_access(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, got);
    chk("lw_100", got, 32'hDEADBEEF);
    do_access(1'b1, 3'b000, 32'h203, 32'h000000F0, 1'b0, got);
    do_access(1'b0, 3'b000, 32'h203, 32'h0, 1'b0, got);
    chk("lb_203", got, 32'hFFFFFFF0);
    do_access(1'b0, 3'b100, 32'h203, 32'h0, 1'b0, got);
    chk("lbu_203", got, 32'h000000F0);
    do_access(1'b1, 3'b001, 32'h302, 32'h00008001, 1'b0, got);
    do_access(1'b0, 3'b001, 32'h302, 32'h0, 1'b0, got);
    chk("lh_302", got, 32'hFFFF8001);
    do_access(1'b0, 3'b101, 32'h302, 32'h0, 1'b0, got);
    chk("lhu_302", got, 32'h00008001);
    do_access(1'b0, 3'b010, 32'h101, 32'h0, 1'b0, got);
    do_access(1'b0, 3'b001, 32'h103, 32'h0, 1'b0, got);

    // reset in the middle of WAIT with the counter at 5
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'b010; lsu_addr = 32'h400; drop_rsp = 1'b1;
    iss_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h400, wdata: 32'h0});
    repeat (6) @(posedge clk);
    #2;
    chk("mid_wait_stall", {31'd0, lsu_stall}, 32'd1);
    arst = 1'b1;
    #1;
    chk_outs_zero("rst_wait");
    lsu_req = 1'b0; drop_rsp = 1'b0;
    @(posedge clk); #1;
    arst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", {29'd0, lsu_stall, lsu_done, lsu_err}, 32'd0);
    end
    @(posedge clk); #1;

    // timeout, then a late response that must be ignored
    do_access(1'b0, 3'b010, 32'h500, 32'h0, 1'b1, got);
    force_rvalid = 1'b1;
    @(negedge clk);
    chk("late_rvalid", {30'd0, lsu_done, lsu_err}, 32'd0);
    @(posedge clk); #1;
    force_rvalid = 1'b0;

    // randomized traffic with idle gaps and stray responses
    for (int k = 0; k < 300; k++) begin
      a = 32'h1000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      do_access(1'($urandom_range(0, 1)), sizes[$urandom_range(0, 9) % 8], a, $urandom,
                ($urandom_range(0, 29) == 0), got);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        force_rvalid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      force_rvalid = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("iss_q_empty", iss_q.size(), 32'd0);
    chk("done_q_empty", done_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/miriscv_lsu.md
Name: miriscv_lsu

Overview:
Load/store unit between the core execute stage and the data port of the single-cycle-latency synchronous RAM.
- Converts core load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned RAM accesses with byte enables and replicated write data.
- Stalls the core until the RAM response arrives, then extracts and sign- or zero-extends the addressed bytes.
- Detects misaligned accesses and bounds the wait with a response timeout.

Parameters:
RSP_TIMEOUT, 16, number of cycles in WAIT without data_rvalid_i before the access is aborted with lsu_err_o (minimum 2).

Ports:
clk_i  input  1  clock, all state updates on rising edge
arst_i  input  1  asynchronous reset, active-high
lsu_req_i  input  1  core requests an access; held with all core inputs stable while lsu_stall_o=1
lsu_we_i  input  1  1=store, 0=load
lsu_size_i  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W
lsu_addr_i  input  32  byte address
lsu_wdata_i  input  32  store data, right-aligned
lsu_rdata_o  output  32  load result, valid only when lsu_done_o=1 and lsu_we_i=0
lsu_stall_o  output  1  core must hold its request
lsu_done_o  output  1  access finished this cycle
lsu_misalign_o  output  1  access rejected as misaligned, single cycle
lsu_err_o  output  1  response timeout, single cycle
data_req_o  output  1  RAM request
data_we_o  output  1  RAM write enable
data_be_o  output  4  RAM byte enables
data_addr_o  output  32  RAM address, {lsu_addr_i[31:2],2'b00}
data_wdata_o  output  32  RAM write data
data_rvalid_i  input  1  RAM response valid, one cycle after the request
data_rdata_i  input  32  RAM read word

Behaviour:
- Clocking and reset: one clock domain, clk_i; reset is asynchronous and active-high on arst_i.
- While arst_i=1, every output is 0.
- Reset clears state to IDLE, the timeout counter to 0, and the offset/size/we registers to 0.
- Reset during WAIT abandons the access; no done/err is produced.
- FSM states are IDLE and WAIT.
- IDLE, lsu_req_i=0: all outputs 0.
- IDLE, lsu_req_i=1, misaligned: data_req_o=0, lsu_misalign_o=1, lsu_done_o=1, lsu_stall_o=0, stay in IDLE.
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
- IDLE, lsu_req_i=1, aligned: combinational issue. data_req_o=1, data_we_o=lsu_we_i, lsu_stall_o=1.
  - The unit registers addr[1:0], size and we, then goes to WAIT with the counter at 0.
- Byte enables and write data (loads drive the same be; the RAM ignores it):
  - B/BU: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - H/HU: be=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}.
  - W: be=4'b1111, wdata=wdata.
- WAIT: data_req_o=0.
  - If data_rvalid_i=1: lsu_done_o=1, lsu_stall_o=0, return to IDLE. For loads, lsu_rdata_o is formatted combinationally from data_rdata_i in the same cycle; for stores, lsu_rdata_o=0.
  - Else: lsu_stall_o=1 and the counter increments.
- Timeout: when the counter equals RSP_TIMEOUT-1 and data_rvalid_i=0, then lsu_err_o=1, lsu_done_o=1, lsu_stall_o=0, lsu_rdata_o=0, return to IDLE.
- Load formatting: sel = data_rdata_i >> (8*off).
  - B: sign-extend sel[7:0]. BU: zero-extend sel[7:0].
  - H: sign-extend sel[15:0]. HU: zero-extend sel[15:0].
  - W: data_rdata_i.
- Nominal latency: aligned access stalls exactly 1 cycle (issue cycle); done is in the following cycle.
- Back-to-back accesses: the IDLE issue can occur in the cycle right after done, giving full one-access-per-two-cycles throughput.
- data_rvalid_i in IDLE (stray or late after timeout) is ignored.
- lsu_done_o, lsu_misalign_o and lsu_err_o are mutually consistent: err and misalign each imply done; err and misalign never occur together.

Test Plan:
- Reset: assert arst_i mid-WAIT (timeout counter at 5) → all outputs 0 immediately. After release with no request, lsu_stall_o=0 and no done/err appears.
- SW then LW: SW addr 0x100, wdata 0xDEADBEEF → be=1111, one stall cycle, done. LW addr 0x100 → lsu_rdata_o=0xDEADBEEF.
- SB/LB/LBU: SB addr 0x203, wdata 0x000000F0 → be=1000, data_wdata_o=0xF0F0F0F0. LB addr 0x203 → 0xFFFFFFF0. LBU addr 0x203 → 0x000000F0.
- SH/LH/LHU: SH addr 0x302, wdata 0x00008001 → be=1100. LH → 0xFFFF8001; LHU → 0x00008001.
- Misalign: LW addr 0x101 and LH addr 0x103 → lsu_misalign_o=1 and done in the same cycle, data_req_o=0, no stall.
- Timeout: hold data_rvalid_i=0 with RSP_TIMEOUT=16 → stall for 16 cycles including issue; lsu_err_o=1 on the 16th WAIT cycle. A late rvalid one cycle later produces no done.
